// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares the single piezo output between the alarm ring,
// the hourly chime and the key click. Fixed priority, pattern timing and
// gated square-wave tone generation.
module buzzer_arbiter #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned ALARM_SEC     = 30,
    parameter int unsigned CHIME_BEEPS   = 2,
    parameter int unsigned CLICK_CYC     = 20,
    parameter int unsigned TONE_DIV      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic       click_req,
    input  logic       cancel,
    output logic       buzz,
    output logic       busy,
    output logic [1:0] owner,
    output logic       alarm_done
);

    localparam int unsigned MAX_SEC = (ALARM_SEC > CHIME_BEEPS) ? ALARM_SEC : CHIME_BEEPS;
    localparam int unsigned PH_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SEC_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC + 1) : 1;
    localparam int unsigned TD_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    // Encoding equals the owner code so owner is a plain copy of the state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        CHIME = 2'd2,
        CLICK = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              restart;
    logic              done_nxt;
    logic [PH_W-1:0]   phase;
    logic [SEC_W-1:0]  sec;
    logic [TD_W-1:0]   tone_div;
    logic              tone_q;
    logic [31:0]       phase_ext;
    logic [31:0]       sec_ext;
    logic [31:0]       tone_div_ext;
    logic              phase_wrap;
    logic              pattern_end;
    logic              on_window;

    assign phase_ext    = 32'(phase);
    assign sec_ext      = 32'(sec);
    assign tone_div_ext = 32'(tone_div);
    assign busy         = (state != IDLE);
    assign owner        = state;

    // Pattern timing: end-of-pattern detection and the audible window per state.
    always_comb begin
        phase_wrap  = (phase_ext == TICKS_PER_SEC - 1);
        pattern_end = 1'b0;
        on_window   = 1'b0;
        case (state)
            ALARM: begin
                pattern_end = phase_wrap && (sec_ext == ALARM_SEC - 1);
                on_window   = (phase_ext < TICKS_PER_SEC / 2);
            end
            CHIME: begin
                pattern_end = phase_wrap && (sec_ext == CHIME_BEEPS - 1);
                on_window   = (phase_ext < TICKS_PER_SEC / 2);
            end
            CLICK: begin
                pattern_end = (phase_ext == CLICK_CYC - 1);
                on_window   = (phase_ext < CLICK_CYC);
            end
            default: begin
                pattern_end = 1'b0;
                on_window   = 1'b0;
            end
        endcase
    end

    // Arbitration: cancel first, then alarm > chime > click, then timeout.
    // Any state entry (including re-entry of the same state) restarts timing.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        done_nxt  = 1'b0;
        if (cancel) begin
            state_nxt = IDLE;
            restart   = 1'b1;
            done_nxt  = (state == ALARM);
        end else if (alarm_req) begin
            state_nxt = ALARM;
            restart   = 1'b1;
            done_nxt  = (state == ALARM);
        end else if (chime_req && (state != ALARM)) begin
            state_nxt = CHIME;
            restart   = 1'b1;
        end else if (click_req && ((state == IDLE) || (state == CLICK))) begin
            state_nxt = CLICK;
            restart   = 1'b1;
        end else if (pattern_end) begin
            state_nxt = IDLE;
            restart   = 1'b1;
            done_nxt  = (state == ALARM);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase/second counters and tone divider; all cleared on entry and while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            sec      <= '0;
            tone_div <= '0;
            tone_q   <= 1'b0;
        end else if (restart || !busy) begin
            phase    <= '0;
            sec      <= '0;
            tone_div <= '0;
            tone_q   <= 1'b0;
        end else begin
            if (phase_wrap) begin
                phase <= '0;
                sec   <= sec + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
            if (tone_div_ext == TONE_DIV - 1) begin
                tone_div <= '0;
                tone_q   <= ~tone_q;
            end else begin
                tone_div <= tone_div + 1'b1;
            end
        end
    end

    // Registered outputs: gated tone and the alarm completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz       <= 1'b0;
            alarm_done <= 1'b0;
        end else begin
            buzz       <= busy & on_window & tone_q;
            alarm_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed scenarios plus randomized requests checked
// against a time-since-entry reference model of the buzzer arbiter.
module tb_buzzer_arbiter;

    localparam int TPS    = 10;
    localparam int ASEC   = 3;
    localparam int CBEEPS = 2;
    localparam int CCYC   = 2;
    localparam int TDIV   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm_req = 1'b0;
    logic       chime_req = 1'b0;
    logic       click_req = 1'b0;
    logic       cancel = 1'b0;
    logic       buzz;
    logic       busy;
    logic [1:0] owner;
    logic       alarm_done;

    int checks = 0;
    int passed = 0;

    // Reference model: active pattern (0 idle, 1 alarm, 2 chime, 3 click)
    // and number of cycles elapsed since the pattern was entered.
    int m_mode = 0;
    int m_t    = 0;
    bit m_done = 1'b0;
    bit m_buzz = 1'b0;

    buzzer_arbiter #(
        .TICKS_PER_SEC(TPS),
        .ALARM_SEC(ASEC),
        .CHIME_BEEPS(CBEEPS),
        .CLICK_CYC(CCYC),
        .TONE_DIV(TDIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alarm_req(alarm_req),
        .chime_req(chime_req),
        .click_req(click_req),
        .cancel(cancel),
        .buzz(buzz),
        .busy(busy),
        .owner(owner),
        .alarm_done(alarm_done)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int mode);
        case (mode)
            1: return TPS * ASEC;
            2: return TPS * CBEEPS;
            3: return CCYC;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_done = 1'b0;
        m_buzz = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit c, input bit k, input bit x);
        bit on;
        on = 1'b0;
        if (m_mode == 1 || m_mode == 2) on = (m_t % TPS) < (TPS / 2);
        else if (m_mode == 3) on = (m_t < CCYC);
        m_buzz = (m_mode != 0) && on && (((m_t / TDIV) % 2) == 1);
        m_done = 1'b0;
        if (x) begin
            m_done = (m_mode == 1);
            m_mode = 0;
            m_t    = 0;
        end else if (a) begin
            m_done = (m_mode == 1);
            m_mode = 1;
            m_t    = 0;
        end else if (c && m_mode != 1) begin
            m_mode = 2;
            m_t    = 0;
        end else if (k && (m_mode == 0 || m_mode == 3)) begin
            m_mode = 3;
            m_t    = 0;
        end else if (m_mode != 0) begin
            m_t++;
            if (m_t == dur(m_mode)) begin
                m_done = (m_mode == 1);
                m_mode = 0;
                m_t    = 0;
            end
        end
    endtask

    // One clock: drive pulses, advance the model on the edge, sample at negedge.
    task automatic cycle(input bit a, input bit c, input bit k, input bit x);
        alarm_req = a;
        chime_req = c;
        click_req = k;
        cancel    = x;
        @(posedge clk);
        model_step(a, c, k, x);
        @(negedge clk);
        alarm_req = 1'b0;
        chime_req = 1'b0;
        click_req = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (buzz !== 1'b0) $display("FAIL reset_buzz got %0b want 0", buzz); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
        checks++; if (owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", owner); else passed++;
        checks++; if (alarm_done !== 1'b0) $display("FAIL reset_done got %0b want 0", alarm_done); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        checks++; if (owner !== 2'd0) $display("FAIL reset_idle_owner got %0d want 0", owner); else passed++;
    endtask

    task automatic test_click();
        int exp_owner [4];
        int exp_buzz  [4];
        exp_owner = '{3, 3, 0, 0};
        exp_buzz  = '{0, 0, 1, 0};
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle(0, 0, 0, 0);
            checks++;
            if (owner !== 2'(exp_owner[i])) $display("FAIL click_owner[%0d] got %0d want %0d", i, owner, exp_owner[i]);
            else passed++;
            checks++;
            if (buzz !== 1'(exp_buzz[i])) $display("FAIL click_buzz[%0d] got %0b want %0d", i, buzz, exp_buzz[i]);
            else passed++;
        end
    endtask

    task automatic test_alarm();
        int busy_cnt;
        int buzz_cnt;
        int done_cnt;
        int done_at_fall;
        bit prev_busy;
        cycle(1, 0, 0, 0);
        busy_cnt = busy ? 1 : 0;
        buzz_cnt = buzz ? 1 : 0;
        done_cnt = 0;
        done_at_fall = 0;
        prev_busy = busy;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 0);
            if (busy) busy_cnt++;
            if (buzz) buzz_cnt++;
            if (alarm_done) begin
                done_cnt++;
                if (prev_busy && !busy) done_at_fall++;
            end
            prev_busy = busy;
        end
        checks++; if (busy_cnt !== 30) $display("FAIL alarm_busy_len got %0d want 30", busy_cnt); else passed++;
        checks++; if (buzz_cnt !== 6) $display("FAIL alarm_buzz_high got %0d want 6", buzz_cnt); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL alarm_done_count got %0d want 1", done_cnt); else passed++;
        checks++; if (done_at_fall !== 1) $display("FAIL alarm_done_at_fall got %0d want 1", done_at_fall); else passed++;
    endtask

    task automatic test_preempt();
        int alarm_len;
        bit chime_seen;
        cycle(0, 1, 0, 0);
        checks++; if (owner !== 2'd2) $display("FAIL preempt_chime_owner got %0d want 2", owner); else passed++;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        checks++; if (owner !== 2'd2) $display("FAIL preempt_before got %0d want 2", owner); else passed++;
        cycle(1, 0, 0, 0);
        checks++; if (owner !== 2'd1) $display("FAIL preempt_after got %0d want 1", owner); else passed++;
        alarm_len = 1;
        for (int i = 0; i < 60 && busy; i++) begin
            cycle(0, 0, 0, 0);
            if (busy) alarm_len++;
        end
        checks++; if (alarm_len !== 30) $display("FAIL preempt_alarm_len got %0d want 30", alarm_len); else passed++;
        chime_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cycle(0, 0, 0, 0);
            if (owner != 2'd0) chime_seen = 1'b1;
        end
        checks++; if (chime_seen !== 1'b0) $display("FAIL preempt_no_resume got %0b want 0", chime_seen); else passed++;
    endtask

    task automatic test_ignore();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, (i == 2 || i == 8), (i == 5 || i == 8), 0);
            checks++;
            if (owner !== 2'd1) $display("FAIL ignore_owner[%0d] got %0d want 1", i, owner);
            else passed++;
        end
        cycle(0, 0, 0, 1);
        checks++; if (owner !== 2'd0) $display("FAIL cancel_alarm_owner got %0d want 0", owner); else passed++;
        checks++; if (alarm_done !== 1'b1) $display("FAIL cancel_alarm_done got %0b want 1", alarm_done); else passed++;
        cycle(0, 1, 1, 0);
        checks++; if (owner !== 2'd2) $display("FAIL simul_chime_click got %0d want 2", owner); else passed++;
        cycle(0, 0, 1, 0);
        checks++; if (owner !== 2'd2) $display("FAIL click_under_chime got %0d want 2", owner); else passed++;
        cycle(0, 0, 0, 1);
        checks++; if (alarm_done !== 1'b0) $display("FAIL chime_cancel_done got %0b want 0", alarm_done); else passed++;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic test_cancel();
        cycle(1, 0, 0, 1);
        checks++; if (owner !== 2'd0) $display("FAIL cancel_same_owner got %0d want 0", owner); else passed++;
        checks++; if (alarm_done !== 1'b0) $display("FAIL cancel_same_done got %0b want 0", alarm_done); else passed++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (owner !== 2'd0 || buzz !== 1'b0)
                $display("FAIL cancel_same_quiet[%0d] got owner=%0d buzz=%0b want 0/0", i, owner, buzz);
            else passed++;
        end
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++; if (alarm_done !== 1'b1) $display("FAIL restart_done got %0b want 1", alarm_done); else passed++;
        checks++; if (owner !== 2'd1) $display("FAIL restart_owner got %0d want 1", owner); else passed++;
        cycle(0, 0, 0, 0);
        checks++; if (alarm_done !== 1'b0) $display("FAIL restart_done_width got %0b want 0", alarm_done); else passed++;
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++; if (buzz !== 1'b1) $display("FAIL chime_buzz_pre got %0b want 1", buzz); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (buzz !== 1'b0 || busy !== 1'b0 || owner !== 2'd0)
            $display("FAIL reset_mid got buzz=%0b busy=%0b owner=%0d want 0/0/0", buzz, busy, owner);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(0, 0, 0, 0);
            checks++;
            if (busy !== 1'b0 || buzz !== 1'b0)
                $display("FAIL reset_mid_idle[%0d] got busy=%0b buzz=%0b want 0/0", i, busy, buzz);
            else passed++;
        end
    endtask

    task automatic test_random();
        bit a, c, k, x;
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(199) == 0);
            c = ($urandom_range(59) == 0);
            k = ($urandom_range(14) == 0);
            x = ($urandom_range(149) == 0);
            cycle(a, c, k, x);
            checks++;
            if (owner !== 2'(m_mode)) $display("FAIL rand_owner[%0d] got %0d want %0d", i, owner, m_mode);
            else passed++;
            checks++;
            if (busy !== (m_mode != 0)) $display("FAIL rand_busy[%0d] got %0b want %0b", i, busy, (m_mode != 0));
            else passed++;
            checks++;
            if (buzz !== m_buzz) $display("FAIL rand_buzz[%0d] got %0b want %0b", i, buzz, m_buzz);
            else passed++;
            checks++;
            if (alarm_done !== m_done) $display("FAIL rand_done[%0d] got %0b want %0b", i, alarm_done, m_done);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_alarm();
        test_preempt();
        test_ignore();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
